maze_move_ctrl: RTL

Player-movement controller for the maze game. Collects direction requests from the keyboard and the push-buttons, grants at most one per video frame by round-robin, and checks the target cell against the wall map over a request/acknowledge read port. It owns the player position and the win flag. It sits between the input decoders and the VGA renderer, and it sequences the map lookup and the position update.

---
 rtl/maze_pkg.sv | 27 ++
 rtl/move_arbiter.sv | 78 +++++++
 rtl/maze_move_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared types and defaults for the maze movement controller.
// Optional map-ack timeout is enabled with MAZE_MOVE_TIMEOUT_EN.
package maze_pkg;

  localparam logic [3:0] DIR_DN    = 4'b0001;
  localparam logic [3:0] DIR_RIGHT = 4'b0010;
  localparam logic [3:0] DIR_UP    = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  localparam int MAP_W_DEF       = 20;
  localparam int MAP_H_DEF       = 15;
  localparam int EXIT_X_DEF      = 17;
  localparam int EXIT_Y_DEF      = 14;
  localparam int TIMEOUT_CYC_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_UPDATE = 2'd2,
    ST_WON    = 2'd3
  } state_e;

  function automatic logic dir_legal(input logic [3:0] d);
    return (d == DIR_DN) || (d == DIR_RIGHT) || (d == DIR_UP) || (d == DIR_LEFT);
  endfunction

endpackage

// File: rtl/move_arbiter.sv
// Two pending direction slots (keyboard, buttons) with round-robin grant.
module move_arbiter
  import maze_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       kbd_valid,
  input  logic [3:0] kbd_dir,
  input  logic       btn_valid,
  input  logic [3:0] btn_dir,
  input  logic       take_kbd,
  input  logic       take_btn,
  input  logic       flush,
  output logic       grant_valid,
  output logic [3:0] grant_dir,
  output logic       grant_src
);

  logic       kbd_pend_q, kbd_pend_d;
  logic [3:0] kbd_dir_q, kbd_dir_d;
  logic       btn_pend_q, btn_pend_d;
  logic [3:0] btn_dir_q, btn_dir_d;
  logic       prio_q, prio_d;  // 0: keyboard preferred, 1: buttons preferred

  logic kbd_wr, btn_wr;

  assign kbd_wr = kbd_valid && dir_legal(kbd_dir) && !flush;
  assign btn_wr = btn_valid && dir_legal(btn_dir) && !flush;

  assign grant_valid = kbd_pend_q || btn_pend_q;
  assign grant_src   = btn_pend_q && (!kbd_pend_q || prio_q);
  assign grant_dir   = grant_src ? btn_dir_q : kbd_dir_q;

  // A strobe landing in the grant cycle wins over the clear.
  always_comb begin
    kbd_pend_d = kbd_pend_q;
    kbd_dir_d  = kbd_dir_q;
    btn_pend_d = btn_pend_q;
    btn_dir_d  = btn_dir_q;
    prio_d     = prio_q;
    if (flush) begin
      kbd_pend_d = 1'b0;
      btn_pend_d = 1'b0;
    end else begin
      if (kbd_wr) begin
        kbd_pend_d = 1'b1;
        kbd_dir_d  = kbd_dir;
      end else if (take_kbd) begin
        kbd_pend_d = 1'b0;
      end
      if (btn_wr) begin
        btn_pend_d = 1'b1;
        btn_dir_d  = btn_dir;
      end else if (take_btn) begin
        btn_pend_d = 1'b0;
      end
    end
    if (take_kbd) prio_d = 1'b1;
    if (take_btn) prio_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_pend_q <= 1'b0;
      kbd_dir_q  <= 4'd0;
      btn_pend_q <= 1'b0;
      btn_dir_q  <= 4'd0;
      prio_q     <= 1'b0;
    end else begin
      kbd_pend_q <= kbd_pend_d;
      kbd_dir_q  <= kbd_dir_d;
      btn_pend_q <= btn_pend_d;
      btn_dir_q  <= btn_dir_d;
      prio_q     <= prio_d;
    end
  end

endmodule

// File: rtl/maze_move_ctrl.sv
// Player-movement controller: one granted move per frame, wall lookup, win flag.
// Define MAZE_MOVE_TIMEOUT_EN to give up on a map lookup after TIMEOUT_CYC cycles.
module maze_move_ctrl
  import maze_pkg::*;
#(
  parameter int MAP_W       = MAP_W_DEF,
  parameter int MAP_H       = MAP_H_DEF,
  parameter int EXIT_X      = EXIT_X_DEF,
  parameter int EXIT_Y      = EXIT_Y_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       restart,
  input  logic       kbd_valid,
  input  logic [3:0] kbd_dir,
  input  logic       btn_valid,
  input  logic [3:0] btn_dir,
  output logic       map_rd_req,
  output logic [4:0] map_rd_x,
  output logic [3:0] map_rd_y,
  input  logic       map_rd_ack,
  input  logic       map_rd_wall,
  output logic [4:0] px,
  output logic [3:0] py,
  output logic       win,
  output logic       busy,
  output logic       move_done,
  output logic       move_blocked
);

  if (TIMEOUT_CYC < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_e     state_q, state_d;
  logic [4:0] px_q, px_d, tx_q, tx_d;
  logic [3:0] py_q, py_d, ty_q, ty_d;
  logic       win_q, win_d;
  logic       blk_q, blk_d;

  logic       grant_valid, grant_src, grant_take;
  logic [3:0] grant_dir;
  logic [4:0] nx;
  logic [3:0] ny;
  logic       oob;
  logic       lookup_tmo;

  move_arbiter u_arb (
    .clk        (clk),
    .reset      (reset),
    .kbd_valid  (kbd_valid),
    .kbd_dir    (kbd_dir),
    .btn_valid  (btn_valid),
    .btn_dir    (btn_dir),
    .take_kbd   (grant_take && !grant_src),
    .take_btn   (grant_take && grant_src),
    .flush      (state_q == ST_WON),
    .grant_valid(grant_valid),
    .grant_dir  (grant_dir),
    .grant_src  (grant_src)
  );

`ifdef MAZE_MOVE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q;

  // Counts cycles spent in LOOKUP; restarts from zero on every entry.
  always_ff @(posedge clk) begin
    if (reset || state_q != ST_LOOKUP) tmo_q <= '0;
    else                               tmo_q <= tmo_q + 1'b1;
  end

  assign lookup_tmo = (tmo_q == TW'(TIMEOUT_CYC - 1));
`else
  assign lookup_tmo = 1'b0;
`endif

  // Target cell and bounds check for the currently granted direction.
  always_comb begin
    nx  = px_q;
    ny  = py_q;
    oob = 1'b0;
    case (grant_dir)
      DIR_DN: begin
        oob = (py_q == 4'(MAP_H - 1));
        ny  = py_q + 4'd1;
      end
      DIR_RIGHT: begin
        oob = (px_q == 5'(MAP_W - 1));
        nx  = px_q + 5'd1;
      end
      DIR_UP: begin
        oob = (py_q == 4'd0);
        ny  = py_q - 4'd1;
      end
      DIR_LEFT: begin
        oob = (px_q == 5'd0);
        nx  = px_q - 5'd1;
      end
      default: oob = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    py_d       = py_q;
    tx_d       = tx_q;
    ty_d       = ty_q;
    win_d      = win_q;
    blk_d      = 1'b0;
    grant_take = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick && grant_valid) begin
          grant_take = 1'b1;
          if (oob) begin
            blk_d = 1'b1;
          end else begin
            tx_d    = nx;
            ty_d    = ny;
            state_d = ST_LOOKUP;
          end
        end
      end
      ST_LOOKUP: begin
        if (map_rd_ack) begin
          if (map_rd_wall) begin
            blk_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_UPDATE;
          end
        end else if (lookup_tmo) begin
          blk_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        px_d = tx_q;
        py_d = ty_q;
        if (tx_q == 5'(EXIT_X) && ty_q == 4'(EXIT_Y)) begin
          win_d   = 1'b1;
          state_d = ST_WON;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WON: begin
        if (restart) begin
          px_d    = 5'd0;
          py_d    = 4'd0;
          win_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      px_q    <= 5'd0;
      py_q    <= 4'd0;
      tx_q    <= 5'd0;
      ty_q    <= 4'd0;
      win_q   <= 1'b0;
      blk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      win_q   <= win_d;
      blk_q   <= blk_d;
    end
  end

  // Target registers only change on entry to LOOKUP, so x/y hold while req is high.
  assign map_rd_req   = (state_q == ST_LOOKUP);
  assign map_rd_x     = tx_q;
  assign map_rd_y     = ty_q;
  assign px           = px_q;
  assign py           = py_q;
  assign win          = win_q;
  assign busy         = (state_q != ST_IDLE);
  assign move_done    = (state_q == ST_UPDATE);
  assign move_blocked = blk_q;

endmodule
